// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Saturating vs. wrap-around boundaries are selected by UPDOWN_COUNTER_SATURATE_EN.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [31:0] Q_RST   = 32'd0;
  localparam logic        TC_RST  = 1'b0;
  localparam logic        DIR_RST = DIR_UP;

  // Limit a load value to the terminal count.
  function automatic logic [31:0] clamp(input logic [31:0] value, input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/updown_next_val.sv
// Combinational next-count and boundary-hit logic for one count step.
// UPDOWN_COUNTER_SATURATE_EN: hold at the boundary instead of wrapping.
module updown_next_val
  import counter_pkg::*;
#(
  parameter int unsigned   N       = 4,
  parameter logic [N-1:0]  MAX_VAL = {N{1'b1}}
) (
  input  logic [N-1:0] q_i,
  input  logic         up_down_i,
  output logic [N-1:0] q_nxt_c,
  output logic         hit_c
);

  always_comb begin
    q_nxt_c = q_i;
    hit_c   = 1'b0;
    if (up_down_i == DIR_DOWN) begin
      if (q_i == '0) begin
        hit_c = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
        q_nxt_c = '0;
`else
        q_nxt_c = MAX_VAL;
`endif
      end else begin
        q_nxt_c = q_i - N'(1);
      end
    end else begin
      // >= also folds a forced out-of-range value onto the boundary result.
      if (q_i >= MAX_VAL) begin
        hit_c = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
        q_nxt_c = MAX_VAL;
`else
        q_nxt_c = '0;
`endif
      end else begin
        q_nxt_c = q_i + N'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clamped parallel load, enable and terminal-count pulse.
// UPDOWN_COUNTER_SATURATE_EN selects saturating boundaries (default: modulo MAX_VAL+1).
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned  N       = 4,
  parameter logic [N-1:0] MAX_VAL = {N{1'b1}}
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         L,
  input  logic [N-1:0] R,
  input  logic         E,
  input  logic         up_down,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         dir
);

  logic [N-1:0] q_q, q_d, q_step_c, q_load_c;
  logic         tc_q, tc_d, dir_q, dir_d, hit_c;

  updown_next_val #(
    .N       (N),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .q_i       (q_q),
    .up_down_i (up_down),
    .q_nxt_c   (q_step_c),
    .hit_c     (hit_c)
  );

  assign q_load_c = N'(clamp(32'(R), 32'(MAX_VAL)));

  // Load has priority over count; tc only survives an enabled boundary step.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    dir_d = dir_q;
    if (L) begin
      q_d = q_load_c;
    end else if (E) begin
      q_d   = q_step_c;
      tc_d  = hit_c;
      dir_d = up_down;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_q   <= N'(Q_RST);
      tc_q  <= TC_RST;
      dir_q <= DIR_RST;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      dir_q <= dir_d;
    end
  end

  assign Q   = q_q;
  assign tc  = tc_q;
  assign dir = dir_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: directed boundary cases plus random traffic on a 4-bit/MAX 9 counter
// and an 8-bit/MAX 255 counter, checked against an arithmetic reference model.
module tb_updown_counter_param;

  localparam int MAX1 = 9;
  localparam int MAX2 = 255;
`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int q;
    bit tc;
    bit dir;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       L1, E1, ud1, tc1, dir1;
  logic [3:0] R1, Q1;
  logic       L2, E2, ud2, tc2, dir2;
  logic [7:0] R2, Q2;

  exp_t exp1[$];
  exp_t exp2[$];
  exp_t cur1, cur2, mon1, mon2;
  exp_t rst_val = '{q: 0, tc: 1'b0, dir: 1'b1};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  updown_counter_param #(.N(4), .MAX_VAL(4'd9)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .L(L1), .R(R1), .E(E1), .up_down(ud1),
    .Q(Q1), .tc(tc1), .dir(dir1)
  );

  updown_counter_param #(.N(8), .MAX_VAL(8'd255)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .L(L2), .R(R2), .E(E2), .up_down(ud2),
    .Q(Q2), .tc(tc2), .dir(dir2)
  );

  function automatic void chk(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  // Reference: modulo arithmetic for wrap, min/max for saturation.
  function automatic exp_t model(exp_t cur, int max, bit l, int r, bit e, bit ud);
    exp_t n = cur;
    n.tc = 1'b0;
    if (l) begin
      n.q = (r > max) ? max : r;
    end else if (e) begin
      n.dir = ud;
      if (ud) begin
        n.tc = (cur.q == max);
        n.q  = SAT ? ((cur.q + 1 > max) ? max : cur.q + 1) : (cur.q + 1) % (max + 1);
      end else begin
        n.tc = (cur.q == 0);
        n.q  = SAT ? ((cur.q == 0) ? 0 : cur.q - 1) : (cur.q + max) % (max + 1);
      end
    end
    return n;
  endfunction

  task automatic step1(input bit l, input int r, input bit e, input bit ud);
    @(negedge Clock);
    L1 = l; R1 = 4'(r); E1 = e; ud1 = ud;
    cur1 = model(cur1, MAX1, l, r & 15, e, ud);
    exp1.push_back(cur1);
  endtask

  task automatic step2(input bit l, input int r, input bit e, input bit ud);
    @(negedge Clock);
    L2 = l; R2 = 8'(r); E2 = e; ud2 = ud;
    cur2 = model(cur2, MAX2, l, r & 255, e, ud);
    exp2.push_back(cur2);
  endtask

  // Both counters hold; tc drops on the next edge.
  task automatic quiet();
    @(negedge Clock);
    L1 = 1'b0; E1 = 1'b0; L2 = 1'b0; E2 = 1'b0;
    cur1.tc = 1'b0;
    cur2.tc = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp1.size() != 0 || exp2.size() != 0); i++) @(posedge Clock);
    #2;
    if (exp1.size() != 0 || exp2.size() != 0)
      chk("drain_timeout", exp1.size() + exp2.size(), 0);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_q1"}, int'(Q1), 0);
    chk({tag, "_tc1"}, int'(tc1), 0);
    chk({tag, "_dir1"}, int'(dir1), 1);
    chk({tag, "_q2"}, int'(Q2), 0);
    chk({tag, "_tc2"}, int'(tc2), 0);
    chk({tag, "_dir2"}, int'(dir2), 1);
  endtask

  // Monitor: every edge presents a result; compare against the oldest prediction.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (exp1.size() != 0) begin
        mon1 = exp1.pop_front();
        chk("q1", int'(Q1), mon1.q);
        chk("tc1", int'(tc1), int'(mon1.tc));
        chk("dir1", int'(dir1), int'(mon1.dir));
      end
      if (exp2.size() != 0) begin
        mon2 = exp2.pop_front();
        chk("q2", int'(Q2), mon2.q);
        chk("tc2", int'(tc2), int'(mon2.tc));
        chk("dir2", int'(dir2), int'(mon2.dir));
      end
    end
  end

  initial begin
    Resetn = 1'b1;
    L1 = 1'b0; R1 = '0; E1 = 1'b0; ud1 = 1'b0;
    L2 = 1'b0; R2 = '0; E2 = 1'b0; ud2 = 1'b0;
    #1 Resetn = 1'b0;
    #1 rst_chk("reset_async");
    @(negedge Clock);
    Resetn = 1'b1;
    cur1 = rst_val;
    cur2 = rst_val;

    repeat (3) step1(1'b0, 0, 1'b0, 1'b0);
    step1(1'b1, 7, 1'b1, 1'b0);
    step1(1'b1, 12, 1'b1, 1'b0);
    step1(1'b1, 8, 1'b0, 1'b0);
    repeat (3) step1(1'b0, 0, 1'b1, 1'b1);
    step1(1'b1, 1, 1'b0, 1'b0);
    repeat (3) step1(1'b0, 0, 1'b1, 1'b0);
    step1(1'b1, 4, 1'b0, 1'b0);
    step1(1'b0, 0, 1'b1, 1'b1);
    step1(1'b0, 0, 1'b1, 1'b0);
    step1(1'b0, 0, 1'b1, 1'b1);
    quiet();

    step2(1'b1, 255, 1'b0, 1'b0);
    step2(1'b0, 0, 1'b1, 1'b1);
    step2(1'b0, 0, 1'b1, 1'b0);
    repeat (60) step2($urandom_range(7) == 0, int'($urandom_range(255)),
                      $urandom_range(3) != 0, $urandom_range(1) == 1);
    quiet();

    repeat (300) step1($urandom_range(7) == 0, int'($urandom_range(15)),
                       $urandom_range(3) != 0, $urandom_range(1) == 1);
    step1(1'b1, 5, 1'b0, 1'b0);
    drain();

    // Reset lands between the drive of an enabled step and its edge.
    @(negedge Clock);
    L1 = 1'b0; E1 = 1'b1; ud1 = 1'b1;
    #2 Resetn = 1'b0;
    #1 rst_chk("reset_midcount");
    @(posedge Clock);
    #1 rst_chk("reset_held");
    @(negedge Clock);
    E1 = 1'b0;
    Resetn = 1'b1;
    cur1 = rst_val;
    cur2 = rst_val;

    repeat (100) step1($urandom_range(7) == 0, int'($urandom_range(15)),
                       $urandom_range(3) != 0, $urandom_range(1) == 1);
    quiet();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
